// File: rtl/dcache_pkg.sv
// Shared definitions for the direct-mapped data-cache controller: line layout,
// status bit positions, FSM encoding and word select/merge helpers.
package dcache_pkg;

  localparam int LINE_W         = 82;
  localparam int WORDS_PER_LINE = 4;
  localparam int INDEX_W        = 5;
  localparam int WORD_W         = 16;
  localparam int DATA_W         = WORDS_PER_LINE * WORD_W;

  // Line layout: {tag[15:0], w3, w2, w1, w0, valid, dirty}
  localparam int DIRTY_BIT = 0;
  localparam int VALID_BIT = 1;
  localparam int DATA_LSB  = 2;
  localparam int DATA_MSB  = DATA_LSB + DATA_W - 1;
  localparam int TAG_LSB   = DATA_MSB + 1;
  localparam int TAG_MSB   = LINE_W - 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOOKUP = 3'd1,
    WBACK  = 3'd2,
    FILL   = 3'd3,
    UPDATE = 3'd4
  } state_t;

  function automatic logic [WORD_W-1:0] get_word(input logic [DATA_W-1:0] d,
                                                 input logic [1:0] k);
    return d[{k, 4'b0000} +: WORD_W];
  endfunction

  function automatic logic [DATA_W-1:0] put_word(input logic [DATA_W-1:0] d,
                                                 input logic [1:0] k,
                                                 input logic [WORD_W-1:0] w);
    logic [DATA_W-1:0] r;
    r = d;
    r[{k, 4'b0000} +: WORD_W] = w;
    return r;
  endfunction

endpackage

// File: rtl/dcache_burst.sv
// Four-beat memory burst sequencer shared by writeback and fill: word counter,
// request gating and a one-cycle request gap after each completed burst.
module dcache_burst (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       mem_ack,
  output logic       req,
  output logic [1:0] word,
  output logic       beat,
  output logic       done
);

  logic [1:0] cnt;
  logic       gap;

  // gap forces req low for the cycle after a burst so WBACK->FILL is never back-to-back
  assign req  = run && !gap;
  assign beat = req && mem_ack;
  assign done = beat && (cnt == 2'd3);
  assign word = cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 2'd0;
      gap <= 1'b0;
    end else begin
      if (beat) cnt <= cnt + 2'd1;
      gap <= done;
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back/write-allocate data-cache controller (4 x 16-bit words per line).
// `define DCACHE_PERF_EN adds wrapping hit/miss counters o_hit_cnt/o_miss_cnt.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int ADDR_W = 23,
  parameter int TAG_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [15:0]       i_data,
  output logic              o_ack,
  output logic [15:0]       o_data,
  output logic [4:0]        o_ram_addr,
  output logic [81:0]       o_ram_data,
  output logic              o_ram_we,
  input  logic [81:0]       i_ram_data,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [15:0]       o_mem_data,
  input  logic [15:0]       i_mem_data,
  input  logic              i_mem_ack
`ifdef DCACHE_PERF_EN
  ,
  output logic [15:0]       o_hit_cnt,
  output logic [15:0]       o_miss_cnt
`endif
);

  state_t state, state_nxt;

  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [15:0]       req_data;
  logic [DATA_W-1:0] line_buf;
  logic [TAG_W-1:0]  old_tag;

  logic [TAG_W-1:0]   req_tag;
  logic [INDEX_W-1:0] req_idx;
  logic [1:0]         req_off;
  logic [TAG_W-1:0]   ram_tag;
  logic [DATA_W-1:0]  ram_words;
  logic               ram_valid;
  logic               ram_dirty;
  logic               hit;

  logic       burst_run;
  logic       burst_req;
  logic [1:0] burst_word;
  logic       burst_beat;
  logic       burst_done;

  assign req_tag   = req_addr[ADDR_W-1:ADDR_W-TAG_W];
  assign req_idx   = req_addr[6:2];
  assign req_off   = req_addr[1:0];
  assign ram_tag   = i_ram_data[TAG_MSB:TAG_LSB];
  assign ram_words = i_ram_data[DATA_MSB:DATA_LSB];
  assign ram_valid = i_ram_data[VALID_BIT];
  assign ram_dirty = i_ram_data[DIRTY_BIT];
  assign hit       = ram_valid && (ram_tag == req_tag);
  assign burst_run = (state == WBACK) || (state == FILL);

  dcache_burst u_burst (
    .clk     (i_clk),
    .rst_n   (i_rst_n),
    .run     (burst_run),
    .mem_ack (i_mem_ack),
    .req     (burst_req),
    .word    (burst_word),
    .beat    (burst_beat),
    .done    (burst_done)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_req) state_nxt = LOOKUP;
      LOOKUP: begin
        if (hit)                         state_nxt = IDLE;
        else if (ram_valid && ram_dirty) state_nxt = WBACK;
        else                             state_nxt = FILL;
      end
      WBACK:   if (burst_done) state_nxt = FILL;
      FILL:    if (burst_done) state_nxt = UPDATE;
      UPDATE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // On a miss the old line is kept so WBACK can stream it out; FILL then overwrites it word by word.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      req_we   <= 1'b0;
      req_addr <= '0;
      req_data <= '0;
      line_buf <= '0;
      old_tag  <= '0;
    end else begin
      if (state == IDLE && i_req) begin
        req_we   <= i_we;
        req_addr <= i_addr;
        req_data <= i_data;
      end
      if (state == LOOKUP && !hit) begin
        line_buf <= ram_words;
        old_tag  <= ram_tag;
      end
      if (state == FILL && burst_beat)
        line_buf <= put_word(line_buf, burst_word, i_mem_data);
    end
  end

  always_comb begin
    o_ack      = 1'b0;
    o_data     = '0;
    o_ram_addr = '0;
    o_ram_data = '0;
    o_ram_we   = 1'b0;
    o_mem_req  = 1'b0;
    o_mem_we   = 1'b0;
    o_mem_addr = '0;
    o_mem_data = '0;
    case (state)
      IDLE: o_ram_addr = i_addr[6:2];
      LOOKUP: begin
        o_ram_addr = req_idx;
        if (hit) begin
          o_ack  = 1'b1;
          o_data = get_word(ram_words, req_off);
          if (req_we) begin
            o_ram_we   = 1'b1;
            o_ram_data = {req_tag, put_word(ram_words, req_off, req_data), 1'b1, 1'b1};
          end
        end
      end
      WBACK: begin
        o_ram_addr = req_idx;
        o_mem_req  = burst_req;
        o_mem_we   = burst_req;
        o_mem_addr = {old_tag, req_idx, burst_word};
        o_mem_data = get_word(line_buf, burst_word);
      end
      FILL: begin
        o_ram_addr = req_idx;
        o_mem_req  = burst_req;
        o_mem_addr = {req_tag, req_idx, burst_word};
      end
      UPDATE: begin
        o_ram_addr = req_idx;
        o_ram_we   = 1'b1;
        o_ram_data = {req_tag,
                      req_we ? put_word(line_buf, req_off, req_data) : line_buf,
                      1'b1, req_we};
        o_ack      = 1'b1;
        o_data     = get_word(line_buf, req_off);
      end
      default: ;
    endcase
  end

`ifdef DCACHE_PERF_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_hit_cnt  <= '0;
      o_miss_cnt <= '0;
    end else if (state == LOOKUP) begin
      if (hit) o_hit_cnt  <= o_hit_cnt + 16'd1;
      else     o_miss_cnt <= o_miss_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Bench for dcache_ctrl: behavioural line RAM and memory responder, a vector table of
// CPU transactions, then a mid-burst reset sequence.
module tb_dcache_ctrl;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_req;
  logic        i_we;
  logic [22:0] i_addr;
  logic [15:0] i_data;
  logic        o_ack;
  logic [15:0] o_data;
  logic [4:0]  o_ram_addr;
  logic [81:0] o_ram_data;
  logic        o_ram_we;
  logic [81:0] i_ram_data;
  logic        o_mem_req;
  logic        o_mem_we;
  logic [22:0] o_mem_addr;
  logic [15:0] o_mem_data;
  logic [15:0] i_mem_data;
  logic        i_mem_ack;
`ifdef DCACHE_PERF_EN
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;
`endif

  dcache_ctrl dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_req      (i_req),
    .i_we       (i_we),
    .i_addr     (i_addr),
    .i_data     (i_data),
    .o_ack      (o_ack),
    .o_data     (o_data),
    .o_ram_addr (o_ram_addr),
    .o_ram_data (o_ram_data),
    .o_ram_we   (o_ram_we),
    .i_ram_data (i_ram_data),
    .o_mem_req  (o_mem_req),
    .o_mem_we   (o_mem_we),
    .o_mem_addr (o_mem_addr),
    .o_mem_data (o_mem_data),
    .i_mem_data (i_mem_data),
    .i_mem_ack  (i_mem_ack)
`ifdef DCACHE_PERF_EN
    ,
    .o_hit_cnt  (hit_cnt),
    .o_miss_cnt (miss_cnt)
`endif
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  function automatic logic [15:0] mem_rd(input logic [22:0] a);
    return 16'hC000 | {4'h0, a[11:0]};
  endfunction

  // Memory responder: acks every other cycle while requested, logs accepted beats.
  logic [22:0] wr_addr_q[$];
  logic [15:0] wr_data_q[$];
  logic [22:0] rd_addr_q[$];
  logic        prev_wr = 1'b0;
  int          gap_viol = 0;

  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      i_mem_ack  <= 1'b0;
      i_mem_data <= 16'h0;
      prev_wr    <= 1'b0;
    end else begin
      if (o_mem_req && i_mem_ack) begin
        if (o_mem_we) begin
          wr_addr_q.push_back(o_mem_addr);
          wr_data_q.push_back(o_mem_data);
        end else begin
          rd_addr_q.push_back(o_mem_addr);
        end
      end
      i_mem_ack  <= o_mem_req && !i_mem_ack;
      i_mem_data <= mem_rd(o_mem_addr);
      prev_wr    <= o_mem_req && o_mem_we;
      if (prev_wr && o_mem_req && !o_mem_we) gap_viol <= gap_viol + 1;
    end
  end

  // Line RAM with registered read; contents cleared by the system reset.
  logic [81:0] ram [32];
  int          ram_wr_cnt = 0;
  logic [4:0]  last_idx = 5'd0;
  logic [81:0] last_line = 82'd0;

  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < 32; k++) ram[k] <= 82'd0;
      i_ram_data <= 82'd0;
    end else begin
      if (o_ram_we) begin
        ram[o_ram_addr] <= o_ram_data;
        ram_wr_cnt      <= ram_wr_cnt + 1;
        last_idx        <= o_ram_addr;
        last_line       <= o_ram_data;
      end
      i_ram_data <= ram[o_ram_addr];
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic do_req(input logic we, input logic [22:0] addr, input logic [15:0] wd,
                        output int lat, output logic [15:0] dat);
    @(posedge i_clk); #1;
    i_req = 1'b1; i_we = we; i_addr = addr; i_data = wd;
    lat = 0; dat = 16'h0;
    for (int n = 1; n <= 100; n++) begin
      @(negedge i_clk);
      if (o_ack) begin
        lat = n; dat = o_data;
        break;
      end
    end
    @(posedge i_clk); #1;
    i_req = 1'b0; i_we = 1'b0; i_data = 16'h0;
  endtask

  typedef struct {
    logic        we;
    logic [22:0] addr;
    logic [15:0] wdata;
    int          lat;
    logic        chk_data;
    logic [15:0] rdata;
    int          nwr;
    logic [22:0] wb_base;
    logic [63:0] wb_words;
    int          nrd;
    logic [22:0] rd_base;
    int          nram;
    logic [4:0]  ram_idx;
    logic [81:0] ram_line;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int lat;
    logic [15:0] dat;
    int wr0, rd0, ram0;
    int found, acks, reqs;
    logic [63:0] sh;

    vecs[0] = '{1'b0, 23'h000104, 16'h0000, 11, 1'b1, 16'hC104, 0, 23'h0, 64'h0,
                4, 23'h000104, 1, 5'd1,
                {16'h0002, 16'hC107, 16'hC106, 16'hC105, 16'hC104, 2'b10}};
    vecs[1] = '{1'b0, 23'h000105, 16'h0000, 2, 1'b1, 16'hC105, 0, 23'h0, 64'h0,
                0, 23'h0, 0, 5'd0, 82'd0};
    vecs[2] = '{1'b1, 23'h000106, 16'hBEEF, 2, 1'b0, 16'h0000, 0, 23'h0, 64'h0,
                0, 23'h0, 1, 5'd1,
                {16'h0002, 16'hC107, 16'hBEEF, 16'hC105, 16'hC104, 2'b11}};
    vecs[3] = '{1'b0, 23'h000184, 16'h0000, 20, 1'b1, 16'hC184, 4, 23'h000104,
                {16'hC107, 16'hBEEF, 16'hC105, 16'hC104},
                4, 23'h000184, 1, 5'd1,
                {16'h0003, 16'hC187, 16'hC186, 16'hC185, 16'hC184, 2'b10}};
    vecs[4] = '{1'b1, 23'h000208, 16'h1234, 11, 1'b0, 16'h0000, 0, 23'h0, 64'h0,
                4, 23'h000208, 1, 5'd2,
                {16'h0004, 16'hC20B, 16'hC20A, 16'hC209, 16'h1234, 2'b11}};
    vecs[5] = '{1'b0, 23'h00020A, 16'h0000, 2, 1'b1, 16'hC20A, 0, 23'h0, 64'h0,
                0, 23'h0, 0, 5'd0, 82'd0};

    i_rst_n = 1'b0; i_req = 1'b0; i_we = 1'b0; i_addr = 23'h0; i_data = 16'h0;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    check("rst_ack",      o_ack, 0);
    check("rst_data",     o_data, 0);
    check("rst_ram_addr", o_ram_addr, 0);
    check("rst_ram_data", o_ram_data, 0);
    check("rst_ram_we",   o_ram_we, 0);
    check("rst_mem_req",  o_mem_req, 0);
    check("rst_mem_we",   o_mem_we, 0);
    check("rst_mem_addr", o_mem_addr, 0);
    check("rst_mem_data", o_mem_data, 0);
`ifdef DCACHE_PERF_EN
    check("rst_hit_cnt",  hit_cnt, 0);
    check("rst_miss_cnt", miss_cnt, 0);
`endif
    i_rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      wr0 = wr_addr_q.size(); rd0 = rd_addr_q.size(); ram0 = ram_wr_cnt;
      do_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, lat, dat);
      check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      if (vecs[i].chk_data) check($sformatf("v%0d_data", i), dat, vecs[i].rdata);
      check($sformatf("v%0d_mem_writes", i), wr_addr_q.size() - wr0, vecs[i].nwr);
      for (int k = 0; k < vecs[i].nwr && wr0 + k < wr_addr_q.size(); k++) begin
        sh = vecs[i].wb_words >> (16 * k);
        check($sformatf("v%0d_wr%0d_addr", i, k), wr_addr_q[wr0+k], vecs[i].wb_base + 23'(k));
        check($sformatf("v%0d_wr%0d_data", i, k), wr_data_q[wr0+k], sh[15:0]);
      end
      check($sformatf("v%0d_mem_reads", i), rd_addr_q.size() - rd0, vecs[i].nrd);
      for (int k = 0; k < vecs[i].nrd && rd0 + k < rd_addr_q.size(); k++)
        check($sformatf("v%0d_rd%0d_addr", i, k), rd_addr_q[rd0+k], vecs[i].rd_base + 23'(k));
      check($sformatf("v%0d_ram_writes", i), ram_wr_cnt - ram0, vecs[i].nram);
      if (vecs[i].nram == 1) begin
        check($sformatf("v%0d_ram_idx", i), last_idx, vecs[i].ram_idx);
        check($sformatf("v%0d_ram_line", i), last_line, vecs[i].ram_line);
      end
`ifdef DCACHE_PERF_EN
      if (i == 3) begin
        check("perf_hit_cnt",  hit_cnt, 2);
        check("perf_miss_cnt", miss_cnt, 2);
      end
`endif
    end
    check("wback_fill_gap", gap_viol, 0);

    // Reset asserted while the second fill beat is being acknowledged.
    ram0 = ram_wr_cnt; rd0 = rd_addr_q.size();
    @(posedge i_clk); #1;
    i_req = 1'b1; i_we = 1'b0; i_addr = 23'h00030C;
    found = 0;
    for (int n = 0; n < 200; n++) begin
      @(negedge i_clk);
      if (rd_addr_q.size() == rd0 + 1 && i_mem_ack) begin
        found = 1;
        break;
      end
    end
    check("reach_fill_ack2", found, 1);
    i_rst_n = 1'b0;
    #1;
    check("midrst_mem_req", o_mem_req, 0);
    check("midrst_ram_we",  o_ram_we, 0);
    check("midrst_ack",     o_ack, 0);
    i_req = 1'b0;
    repeat (2) @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    acks = 0; reqs = 0;
    for (int n = 0; n < 6; n++) begin
      @(negedge i_clk);
      if (o_ack) acks++;
      if (o_mem_req) reqs++;
    end
    check("postrst_acks",     acks, 0);
    check("postrst_mem_reqs", reqs, 0);
    check("postrst_ram_writes", ram_wr_cnt - ram0, 0);
    check("postrst_idle_addr", o_ram_addr, 5'd3);
`ifdef DCACHE_PERF_EN
    check("postrst_hit_cnt",  hit_cnt, 0);
    check("postrst_miss_cnt", miss_cnt, 0);
`endif

    do_req(1'b0, 23'h00030C, 16'h0, lat, dat);
    check("refill_latency", lat, 11);
    check("refill_data",    dat, 16'hC30C);
    check("refill_ram_line", last_line,
          {16'h0006, 16'hC30F, 16'hC30E, 16'hC30D, 16'hC30C, 2'b10});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
